// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - default sizing constants and log2 helper for fifo_sync_param
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 5;
  localparam int FIFO_DEF_DEPTH = 8;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int fifo_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake and status bundle of the FIFO
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
) ();

  localparam int AW = fifo_log2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] DataIn;
  logic             rd_en;
  logic [WIDTH-1:0] DataOut;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, DataIn, rd_en,
    input  DataOut, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, DataIn, rd_en,
    output DataOut, full, empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/reg_nb_load_en.sv
// rtl/reg_nb_load_en.sv - WIDTH-bit register with load enable and async active-low clear
module reg_nb_load_en #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock WIDTH x DEPTH FIFO on load-enabled registers
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic              clk,
  input logic              clear,
  fifo_sync_param_if.slave bus
);

  localparam int          AW         = fifo_log2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_COUNT   = (AW + 1)'(AF_LEVEL);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [WIDTH-1:0] w_rd_data;

  // Pointers carry one extra wrap bit, so plain subtraction gives 0..DEPTH.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == FULL_COUNT);
  assign w_empty = (w_count == '0);

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign w_rd_acc = bus.rd_en & ~w_empty;
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
      r_overflow  <= bus.wr_en & ~w_wr_acc;
      r_underflow <= bus.rd_en & ~w_rd_acc;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic w_load;
    assign w_load = w_wr_acc & (r_wptr[AW-1:0] == AW'(gi));

    reg_nb_load_en #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk    (clk),
      .clear  (clear),
      .i_load (w_load),
      .i_d    (bus.DataIn),
      .o_q    (w_mem[gi])
    );
  end

  assign w_rd_data = w_mem[r_rptr[AW-1:0]];

  reg_nb_load_en #(
    .WIDTH (WIDTH)
  ) u_dout (
    .clk    (clk),
    .clear  (clear),
    .i_load (w_rd_acc),
    .i_d    (w_rd_data),
    .o_q    (bus.DataOut)
  );

  assign bus.count       = w_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (w_count >= AF_COUNT);
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - random and directed checks of two FIFO configurations against a queue model
module tb_fifo_sync_param;

  logic clk   = 1'b0;
  logic clear = 1'b1;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(5),  .DEPTH(8)) if0 ();
  fifo_sync_param_if #(.WIDTH(16), .DEPTH(2)) if1 ();

  fifo_sync_param #(.WIDTH(5), .DEPTH(8), .AF_LEVEL(7)) u_dut0 (
    .clk   (clk),
    .clear (clear),
    .bus   (if0)
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(2), .AF_LEVEL(1)) u_dut1 (
    .clk   (clk),
    .clear (clear),
    .bus   (if1)
  );

  int total = 0;
  int bad   = 0;

  int q0[$];
  int q1[$];
  int dout0 = 0;
  int dout1 = 0;
  bit ov0 = 0, un0 = 0, ov1 = 0, un1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    dout0 = 0;
    dout1 = 0;
    ov0 = 0; un0 = 0; ov1 = 0; un1 = 0;
  endtask

  // One clock edge: drive at negedge, advance the model at the posedge.
  task automatic step(input bit wr, input bit rd, input int d);
    bit ra, wa;
    @(negedge clk);
    if0.wr_en  = wr;
    if0.rd_en  = rd;
    if0.DataIn = d[4:0];
    if1.wr_en  = wr;
    if1.rd_en  = rd;
    if1.DataIn = d[15:0];
    @(posedge clk);
    ra = rd && (q0.size() > 0);
    wa = wr && ((q0.size() < 8) || ra);
    ov0 = wr && !wa;
    un0 = rd && !ra;
    if (ra) dout0 = q0.pop_front();
    if (wa) q0.push_back(d & 32'h1F);
    ra = rd && (q1.size() > 0);
    wa = wr && ((q1.size() < 2) || ra);
    ov1 = wr && !wa;
    un1 = rd && !ra;
    if (ra) dout1 = q1.pop_front();
    if (wa) q1.push_back(d & 32'hFFFF);
  endtask

  // Called just after a posedge: assert clear mid-cycle, check, release at next negedge.
  task automatic do_clear();
    #2;
    clear      = 1'b0;
    if0.wr_en  = 1'b0;
    if0.rd_en  = 1'b0;
    if1.wr_en  = 1'b0;
    if1.rd_en  = 1'b0;
    #1;
    model_reset();
    chk("clr_count0", 32'(if0.count), 0);
    chk("clr_empty0", 32'(if0.empty), 1);
    chk("clr_full0",  32'(if0.full), 0);
    chk("clr_dout0",  32'(if0.DataOut), 0);
    chk("clr_count1", 32'(if1.count), 0);
    chk("clr_dout1",  32'(if1.DataOut), 0);
    @(negedge clk);
    clear = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("cmp_count0", 32'(if0.count), q0.size());
    chk("cmp_empty0", 32'(if0.empty), 32'(q0.size() == 0));
    chk("cmp_full0",  32'(if0.full), 32'(q0.size() == 8));
    chk("cmp_af0",    32'(if0.almost_full), 32'(q0.size() >= 7));
    chk("cmp_dout0",  32'(if0.DataOut), dout0);
    chk("cmp_ov0",    32'(if0.overflow), 32'(ov0));
    chk("cmp_un0",    32'(if0.underflow), 32'(un0));
    chk("cmp_count1", 32'(if1.count), q1.size());
    chk("cmp_empty1", 32'(if1.empty), 32'(q1.size() == 0));
    chk("cmp_full1",  32'(if1.full), 32'(q1.size() == 2));
    chk("cmp_af1",    32'(if1.almost_full), 32'(q1.size() >= 1));
    chk("cmp_dout1",  32'(if1.DataOut), dout1);
    chk("cmp_ov1",    32'(if1.overflow), 32'(ov1));
    chk("cmp_un1",    32'(if1.underflow), 32'(un1));
  end

  initial begin
    int wp, rp, v;
    if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.DataIn = '0;
    if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.DataIn = '0;
    #1;
    clear = 1'b0;
    #1;
    chk("rst_count0", 32'(if0.count), 0);
    chk("rst_empty0", 32'(if0.empty), 1);
    chk("rst_af0",    32'(if0.almost_full), 0);
    chk("rst_ov0",    32'(if0.overflow), 0);
    chk("rst_dout0",  32'(if0.DataOut), 0);
    repeat (2) @(negedge clk);
    clear = 1'b1;

    // Clear mid-stream with three words held and a non-zero DataOut.
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, k);
    step(1'b0, 1'b1, 0);
    #1 chk("pre_clr_dout", 32'(if0.DataOut), 1);
    chk("pre_clr_count", 32'(if0.count), 3);
    do_clear();
    step(1'b0, 1'b1, 0);
    #1 chk("post_clr_underflow", 32'(if0.underflow), 1);
    step(1'b0, 1'b0, 0);
    #1 chk("underflow_one_cycle", 32'(if0.underflow), 0);

    // Fill 1..8.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, k);
      #1;
      chk("fill_count", 32'(if0.count), k);
      chk("fill_af", 32'(if0.almost_full), 32'(k >= 7));
      if (k == 1) begin
        chk("d2_af_one",   32'(if1.almost_full), 1);
        chk("d2_full_one", 32'(if1.full), 0);
      end
      if (k == 2) chk("d2_full_two", 32'(if1.full), 1);
    end
    chk("fill_full", 32'(if0.full), 1);

    // Write while full with no read.
    step(1'b1, 1'b0, 32'h1F);
    #1 chk("ovf_pulse", 32'(if0.overflow), 1);
    chk("ovf_count", 32'(if0.count), 8);
    step(1'b0, 1'b0, 0);
    #1 chk("ovf_one_cycle", 32'(if0.overflow), 0);

    // Read and write together while full.
    step(1'b1, 1'b1, 32'h0A);
    #1 chk("full_rw_dout", 32'(if0.DataOut), 1);
    chk("full_rw_count", 32'(if0.count), 8);
    chk("full_rw_no_ovf", 32'(if0.overflow), 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 0);
      #1 chk("drain_dout", 32'(if0.DataOut), (k < 7) ? k + 2 : 32'h0A);
    end
    chk("drain_empty", 32'(if0.empty), 1);

    // Read and write together while empty.
    step(1'b1, 1'b1, 32'h15);
    #1 chk("empty_rw_count", 32'(if0.count), 1);
    chk("empty_rw_underflow", 32'(if0.underflow), 1);
    chk("empty_rw_dout", 32'(if0.DataOut), 32'h0A);
    step(1'b0, 1'b1, 0);
    #1 chk("empty_rw_read", 32'(if0.DataOut), 32'h15);

    // Wrap-around at occupancy 3.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, $urandom);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, $urandom);
      #1 chk("wrap_cnt_hi", 32'(if0.count >= 2 && if0.count <= 4), 1);
      step(1'b0, 1'b1, 0);
      #1 chk("wrap_cnt_lo", 32'(if0.count >= 2 && if0.count <= 4), 1);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0);

    // Randomised phases biased toward filling, draining, balanced and busy.
    for (int i = 0; i < 600; i++) begin
      case ((i / 50) % 4)
        0:       begin wp = 80; rp = 20; end
        1:       begin wp = 20; rp = 80; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 90; rp = 90; end
      endcase
      v = $urandom;
      step($urandom_range(99) < wp, $urandom_range(99) < rp, v);
      if (i == 333) do_clear();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
